wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_pkg.sv | 34 +++
 rtl/wb_stage_load_align.sv | 53 +++++
 rtl/wb_stage.sv | 88 ++++++++
 tb/tb_wb_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: load encodings, source
// selects and the WB pipeline control record.
package wb_pkg;

  // RISC-V load funct3 encodings (LD/LWU only meaningful when XLEN=64)
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110
  } load_funct3_e;

  // Source select is stored at 8 bits so the record is independent of NUM_SRC
  typedef logic [7:0] wb_sel_t;

  localparam wb_sel_t WB_SRC_ALU = 8'd0;
  localparam wb_sel_t WB_SRC_MEM = 8'd1;
  localparam wb_sel_t WB_SRC_PC4 = 8'd2;
  localparam wb_sel_t WB_SRC_CSR = 8'd3;

  // Control half of the WB pipeline register (data is held alongside)
  typedef struct packed {
    logic       valid;
    logic       reg_wr;
    logic [4:0] rd_addr;
    wb_sel_t    sel;
    logic [2:0] funct3;
    logic [2:0] byte_off;   // zero-extended; top bit always 0 when XLEN=32
  } wb_ctrl_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data alignment: shifts the memory word down by the byte offset,
// sign/zero-extends per load type and flags misaligned accesses.
module load_align
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      funct3,
  input  logic [2:0]      byte_off,
  output logic [XLEN-1:0] result,
  output logic            misalign
);

  logic [XLEN-1:0] shifted;

  // Extract the addressed sub-word and extend it to XLEN
  always_comb begin
    shifted  = data >> {byte_off, 3'b000};
    result   = shifted;
    misalign = 1'b0;
    case (funct3)
      F3_LB:  result = XLEN'($signed(shifted[7:0]));
      F3_LBU: result = XLEN'(shifted[7:0]);
      F3_LH: begin
        result   = XLEN'($signed(shifted[15:0]));
        misalign = byte_off[0];
      end
      F3_LHU: begin
        result   = XLEN'(shifted[15:0]);
        misalign = byte_off[0];
      end
      F3_LW: begin
        result   = (XLEN == 32) ? data : XLEN'($signed(shifted[31:0]));
        misalign = |byte_off[1:0];
      end
      F3_LWU: begin
        if (XLEN == 64) begin
          result   = XLEN'(shifted[31:0]);
          misalign = |byte_off[1:0];
        end
      end
      F3_LD: begin
        if (XLEN == 64) begin
          result   = data;
          misalign = |byte_off;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: one pipeline register between MEM and the register
// file, result-source mux, load alignment and a retired-instruction counter.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_SRC  = 4,
  parameter int unsigned SEL_W    = $clog2(NUM_SRC),
  // Reset value of the retired counter; 0 in normal use
  parameter logic [31:0] CNT_INIT = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  input  logic [SEL_W-1:0]           mem_to_reg_i,
  input  logic [NUM_SRC*XLEN-1:0]    src_i,
  input  logic [2:0]                 load_funct3_i,
  input  logic [$clog2(XLEN/8)-1:0]  byte_off_i,
  input  logic                       reg_wr_i,
  input  logic [4:0]                 rd_addr_i,
  output logic [XLEN-1:0]            rd_wdata_o,
  output logic [4:0]                 rd_addr_o,
  output logic                       reg_wr_o,
  output logic                       misalign_o,
  output logic [31:0]                retired_cnt_o
);

  localparam int unsigned MEM_LSB = 32'(WB_SRC_MEM) * XLEN;

  wb_ctrl_t                  ctrl_q;
  logic [NUM_SRC*XLEN-1:0]   src_q;
  logic [31:0]               cnt_q;
  logic [XLEN-1:0]           ld_data;
  logic                      ld_mis;
  logic [XLEN-1:0]           pick;
  logic                      legal;

  // WB pipeline register and retire counter; stall freezes both, flush loads a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      src_q  <= '0;
      cnt_q  <= CNT_INIT;
    end else if (!stall_i) begin
      if (ctrl_q.valid) cnt_q <= cnt_q + 32'd1;
      src_q <= src_i;
      if (flush_i) begin
        ctrl_q <= '0;
      end else begin
        ctrl_q <= '{valid:    valid_i,
                    reg_wr:   reg_wr_i,
                    rd_addr:  rd_addr_i,
                    sel:      wb_sel_t'(mem_to_reg_i),
                    funct3:   load_funct3_i,
                    byte_off: 3'(byte_off_i)};
      end
    end
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .data     (src_q[MEM_LSB +: XLEN]),
    .funct3   (ctrl_q.funct3),
    .byte_off (ctrl_q.byte_off),
    .result   (ld_data),
    .misalign (ld_mis)
  );

  // Result-source mux; out-of-range selects fall through to zero
  always_comb begin
    pick  = '0;
    legal = ctrl_q.sel < wb_sel_t'(NUM_SRC);
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (ctrl_q.sel == wb_sel_t'(k)) begin
        pick = (wb_sel_t'(k) == WB_SRC_MEM) ? ld_data : src_q[k*XLEN +: XLEN];
      end
    end
  end

  assign misalign_o    = ctrl_q.valid && (ctrl_q.sel == WB_SRC_MEM) && ld_mis;
  assign rd_wdata_o    = ctrl_q.valid ? pick : '0;
  assign rd_addr_o     = ctrl_q.rd_addr;
  assign reg_wr_o      = ctrl_q.valid && ctrl_q.reg_wr && legal && !misalign_o &&
                         (ctrl_q.rd_addr != 5'd0);
  assign retired_cnt_o = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed table, multi-cycle sequences
// and randomized traffic against a behavioural model.
module tb_wb_stage;
  import wb_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid, stall, flush, reg_wr;
  logic [1:0]   sel;
  logic [127:0] src;
  logic [2:0]   f3;
  logic [1:0]   off;
  logic [4:0]   rd;

  logic [31:0] wdata, wdata_w, wdata_3;
  logic [4:0]  waddr, waddr_w, waddr_3;
  logic        wr, wr_w, wr_3;
  logic        mis, mis_w, mis_3;
  logic [31:0] cnt, cnt_w, cnt_3;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .NUM_SRC(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid), .stall_i(stall), .flush_i(flush),
    .mem_to_reg_i(sel), .src_i(src), .load_funct3_i(f3), .byte_off_i(off),
    .reg_wr_i(reg_wr), .rd_addr_i(rd), .rd_wdata_o(wdata), .rd_addr_o(waddr),
    .reg_wr_o(wr), .misalign_o(mis), .retired_cnt_o(cnt));

  wb_stage #(.XLEN(32), .NUM_SRC(4), .CNT_INIT(32'hFFFF_FFFF)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .valid_i(valid), .stall_i(stall), .flush_i(flush),
    .mem_to_reg_i(sel), .src_i(src), .load_funct3_i(f3), .byte_off_i(off),
    .reg_wr_i(reg_wr), .rd_addr_i(rd), .rd_wdata_o(wdata_w), .rd_addr_o(waddr_w),
    .reg_wr_o(wr_w), .misalign_o(mis_w), .retired_cnt_o(cnt_w));

  wb_stage #(.XLEN(32), .NUM_SRC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid), .stall_i(stall), .flush_i(flush),
    .mem_to_reg_i(sel), .src_i(src[95:0]), .load_funct3_i(f3), .byte_off_i(off),
    .reg_wr_i(reg_wr), .rd_addr_i(rd), .rd_wdata_o(wdata_3), .rd_addr_o(waddr_3),
    .reg_wr_o(wr_3), .misalign_o(mis_3), .retired_cnt_o(cnt_3));

  typedef struct packed {
    logic        valid;
    logic        wr;
    logic        mis;
    logic        chk;     // wdata is defined (not a misaligned load)
    logic [4:0]  addr;
    logic [31:0] data;
  } res_t;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] data;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [4:0]  rd;
    logic        wr_in;
    logic [31:0] exp_data;
    logic        exp_wr;
    logic        exp_mis;
  } vec_t;

  res_t        m, m3;
  logic [31:0] m_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic res_t bubble();
    res_t r;
    r = '0;
    r.chk = 1'b1;
    return r;
  endfunction

  // What the WB stage should present after capturing the current inputs
  function automatic res_t predict(input int unsigned nsrc);
    res_t        r;
    logic [31:0] w, sh;
    int unsigned o, s;
    r = bubble();
    if (!valid) return r;
    r.valid = 1'b1;
    r.addr  = rd;
    s = 32'(sel);
    if (s >= nsrc) return r;
    w = src[s*32 +: 32];
    if (s == 1) begin
      o  = 32'(off);
      sh = w >> (8 * o);
      case (f3)
        3'b000: begin r.data = sh & 32'hFF;   if (sh[7])  r.data = r.data | 32'hFFFF_FF00; end
        3'b100: r.data = sh & 32'hFF;
        3'b001: begin r.data = sh & 32'hFFFF; if (sh[15]) r.data = r.data | 32'hFFFF_0000;
                      r.mis = (o % 2) != 0; end
        3'b101: begin r.data = sh & 32'hFFFF; r.mis = (o % 2) != 0; end
        default: begin r.data = w; r.mis = (o % 4) != 0; end
      endcase
    end else begin
      r.data = w;
    end
    r.chk = !r.mis;
    r.wr  = reg_wr && !r.mis && (rd != 5'd0);
    return r;
  endfunction

  task automatic model_reset();
    m     = bubble();
    m3    = bubble();
    m_cnt = '0;
  endtask

  // Advance one clock with the currently driven inputs and compare both duts to the model
  task automatic tick();
    if (!stall) begin
      if (m.valid) m_cnt = m_cnt + 32'd1;
      if (flush) begin
        m  = bubble();
        m3 = bubble();
      end else begin
        m  = predict(4);
        m3 = predict(3);
      end
    end
    @(posedge clk);
    #1;
    check("reg_wr", 32'(wr), 32'(m.wr));
    check("misalign", 32'(mis), 32'(m.mis));
    if (m.chk)   check("wdata", wdata, m.data);
    if (m.valid) check("waddr", 32'(waddr), 32'(m.addr));
    check("count", cnt, m_cnt);
    check("reg_wr_n3", 32'(wr_3), 32'(m3.wr));
    check("misalign_n3", 32'(mis_3), 32'(m3.mis));
    if (m3.chk)   check("wdata_n3", wdata_3, m3.data);
    if (m3.valid) check("waddr_n3", 32'(waddr_3), 32'(m3.addr));
    check("count_n3", cnt_3, m_cnt);
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [2:0] f,
                       input logic [1:0] o, input logic [4:0] r, input logic w);
    valid  = v;
    sel    = s;
    f3     = f;
    off    = o;
    rd     = r;
    reg_wr = w;
    src    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wdata"}, wdata, 32'h0);
    check({tag, "_waddr"}, 32'(waddr), 32'h0);
    check({tag, "_wr"}, 32'(wr), 32'h0);
    check({tag, "_mis"}, 32'(mis), 32'h0);
    check({tag, "_cnt"}, cnt, 32'h0);
  endtask

  vec_t        tbl[12];
  logic [2:0]  f3s[5];
  res_t        held;
  logic [31:0] held_cnt;

  initial begin
    tbl[0]  = '{2'd0, 32'h0000_1234, 3'b000, 2'd0, 5'd5,  1'b1, 32'h0000_1234, 1'b1, 1'b0};
    tbl[1]  = '{2'd1, 32'h80FF_7F01, 3'b000, 2'd3, 5'd6,  1'b1, 32'hFFFF_FF80, 1'b1, 1'b0};
    tbl[2]  = '{2'd1, 32'h80FF_7F01, 3'b100, 2'd3, 5'd7,  1'b1, 32'h0000_0080, 1'b1, 1'b0};
    tbl[3]  = '{2'd1, 32'h80FF_7F01, 3'b001, 2'd2, 5'd8,  1'b1, 32'hFFFF_80FF, 1'b1, 1'b0};
    tbl[4]  = '{2'd1, 32'h80FF_7F01, 3'b010, 2'd2, 5'd9,  1'b1, 32'h0,         1'b0, 1'b1};
    tbl[5]  = '{2'd0, 32'hDEAD_BEEF, 3'b000, 2'd0, 5'd0,  1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0};
    tbl[6]  = '{2'd2, 32'h0000_1004, 3'b000, 2'd0, 5'd10, 1'b1, 32'h0000_1004, 1'b1, 1'b0};
    tbl[7]  = '{2'd3, 32'hCAFE_F00D, 3'b000, 2'd0, 5'd31, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0};
    tbl[8]  = '{2'd1, 32'h80FF_7F01, 3'b101, 2'd2, 5'd11, 1'b1, 32'h0000_80FF, 1'b1, 1'b0};
    tbl[9]  = '{2'd1, 32'h1234_5678, 3'b010, 2'd0, 5'd12, 1'b1, 32'h1234_5678, 1'b1, 1'b0};
    tbl[10] = '{2'd1, 32'h80FF_7F01, 3'b001, 2'd1, 5'd13, 1'b1, 32'h0,         1'b0, 1'b1};
    tbl[11] = '{2'd1, 32'h0000_00F0, 3'b000, 2'd0, 5'd1,  1'b1, 32'hFFFF_FFF0, 1'b1, 1'b0};
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    // Reset state
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 2'd0, 3'b000, 2'd0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    check("reset_cnt_wrap", cnt_w, 32'hFFFF_FFFF);
    rst_n = 1'b1;
    model_reset();

    // Counter wrap: two instructions retire through the preset instance
    drive(1'b1, 2'd0, 3'b000, 2'd0, 5'd4, 1'b1);
    tick();
    check("wrap_cnt0", cnt_w, 32'hFFFF_FFFF);
    check("wrap_wdata", wdata_w, m.data);
    check("wrap_waddr", 32'(waddr_w), 32'(m.addr));
    check("wrap_wr", 32'(wr_w), 32'(m.wr));
    check("wrap_mis", 32'(mis_w), 32'(m.mis));
    drive(1'b1, 2'd2, 3'b000, 2'd0, 5'd9, 1'b1);
    tick();
    check("wrap_cnt1", cnt_w, 32'h0000_0000);
    drive(1'b0, 2'd0, 3'b000, 2'd0, 5'd0, 1'b0);
    tick();
    check("wrap_cnt2", cnt_w, 32'h0000_0001);

    // Directed vectors, back to back
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, tbl[i].sel, tbl[i].f3, tbl[i].off, tbl[i].rd, tbl[i].wr_in);
      src[32'(tbl[i].sel)*32 +: 32] = tbl[i].data;
      tick();
      check($sformatf("vec%0d_wr", i), 32'(wr), 32'(tbl[i].exp_wr));
      check($sformatf("vec%0d_mis", i), 32'(mis), 32'(tbl[i].exp_mis));
      check($sformatf("vec%0d_waddr", i), 32'(waddr), 32'(tbl[i].rd));
      if (!tbl[i].exp_mis) check($sformatf("vec%0d_wdata", i), wdata, tbl[i].exp_data);
    end

    // Stall for three cycles with fresh inputs, then flush a valid instruction
    drive(1'b1, 2'd0, 3'b000, 2'd0, 5'd3, 1'b1);
    src[31:0] = 32'h0000_ABCD;
    tick();
    held     = m;
    held_cnt = m_cnt;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'($urandom_range(3)), 3'b000, 2'd0, 5'($urandom_range(1, 31)), 1'b1);
      tick();
      check("stall_wdata", wdata, held.data);
      check("stall_wr", 32'(wr), 32'(held.wr));
      check("stall_cnt", cnt, held_cnt);
    end
    stall = 1'b0;
    flush = 1'b1;
    drive(1'b1, 2'd0, 3'b000, 2'd0, 5'd7, 1'b1);
    tick();
    check("flush_wr", 32'(wr), 32'h0);
    check("flush_wdata", wdata, 32'h0);
    check("flush_cnt", cnt, held_cnt + 32'd1);
    flush = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom % 5) == 0;
      flush = ($urandom % 8) == 0;
      drive(($urandom % 4) != 0, 2'($urandom_range(3)), f3s[$urandom_range(4)],
            2'($urandom_range(3)), (($urandom % 6) == 0) ? 5'd0 : 5'($urandom),
            ($urandom % 5) != 0);
      if (($urandom % 3) == 0) src[63:32] = 32'h80FF_7F01;
      tick();
    end

    // Asynchronous reset while a valid instruction is held by stall
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b1, 2'd0, 3'b000, 2'd0, 5'd12, 1'b1);
    tick();
    stall = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    #2;
    rst_n = 1'b1;
    tick();
    check("post_rst_hold_wr", 32'(wr), 32'h0);
    stall = 1'b0;
    tick();
    check("post_rst_capture_wr", 32'(wr), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
